multidigit_counter_7seg: RTL and testbench

MULTIDIGIT_COUNTER_7SEG -- requirements
Module: multidigit_counter_7seg

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_decoder.sv | 36 +++
 rtl/multidigit_counter_7seg.sv | 161 ++++++++++++++++
 tb/tb_multidigit_counter_7seg.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared seven-segment constants. Segment order is [6:0] = a,b,c,d,e,f,g,
//   active-low (0 = segment lit).
//   Ports: none (package).
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder
//   Combinational hex digit to active-low seven-segment glyph lookup.
//   Ports:
//     digit - 4-bit hex value to display
//     seg7  - active-low segments [6:0] = a,b,c,d,e,f,g
module seg7_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg7
);

   always_comb begin
      seg7 = SEG_BLANK;
      case (digit)
         4'h0: seg7 = SEG_0;
         4'h1: seg7 = SEG_1;
         4'h2: seg7 = SEG_2;
         4'h3: seg7 = SEG_3;
         4'h4: seg7 = SEG_4;
         4'h5: seg7 = SEG_5;
         4'h6: seg7 = SEG_6;
         4'h7: seg7 = SEG_7;
         4'h8: seg7 = SEG_8;
         4'h9: seg7 = SEG_9;
         4'hA: seg7 = SEG_A;
         4'hB: seg7 = SEG_B;
         4'hC: seg7 = SEG_C;
         4'hD: seg7 = SEG_D;
         4'hE: seg7 = SEG_E;
         4'hF: seg7 = SEG_F;
         default: seg7 = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/multidigit_counter_7seg.sv
// multidigit_counter_7seg
//   Multi-digit hex/BCD up/down counter with prescaler, optional saturation
//   and a time-multiplexed seven-segment display driver.
//   Ports:
//     clk        - single clock, rising edge
//     rst        - synchronous active-low reset
//     enable     - 1 = prescaler and counter advance
//     upDown     - 1 = count up, 0 = count down
//     load       - 1 = load load_value on the next edge (ignores enable)
//     load_value - value to load, digit 0 in bits [3:0]
//     count      - registered count value
//     terminal   - combinational, count at the limit for the current direction
//     wrap       - registered one-cycle pulse after a wrap-around step
//     seg7       - active-low segments [6:0] = a,b,c,d,e,f,g
//     an         - active-low one-hot digit select
module multidigit_counter_7seg
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int BCD      = 0,
   parameter int SATURATE = 0,
   parameter int TICK_DIV = 1,
   parameter int SCAN_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  upDown,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   output logic [4*DIGITS-1:0]   count,
   output logic                  terminal,
   output logic                  wrap,
   output logic [6:0]            seg7,
   output logic [DIGITS-1:0]     an
);

   localparam int W   = 4 * DIGITS;
   localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SDW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SIW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

   localparam logic [3:0]     DIGIT_MAX  = (BCD != 0) ? 4'd9 : 4'hF;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SDW-1:0] SCAN_LAST  = SDW'(SCAN_DIV - 1);
   localparam logic [SIW-1:0] IDX_LAST   = SIW'(DIGITS - 1);

   logic [PW-1:0]  presc;
   logic           step;
   logic [W-1:0]   count_max;
   logic [W-1:0]   count_next;
   logic [W-1:0]   load_clamped;
   logic           carry;
   logic [3:0]     dig;
   logic [SDW-1:0] scan_div;
   logic [SIW-1:0] scan_idx;
   logic [3:0]     scan_digit;
   logic [6:0]     glyph;
   logic [DIGITS-1:0] an_sel;

   // Limit pattern, next value (ripple carry/borrow) and clamped load value.
   always_comb begin
      count_max    = '0;
      count_next   = count;
      load_clamped = load_value;
      carry        = 1'b1;
      dig          = 4'd0;
      for (int d = 0; d < DIGITS; d++) begin
         count_max[4*d +: 4] = DIGIT_MAX;
         if (BCD != 0 && load_value[4*d +: 4] > 4'd9)
            load_clamped[4*d +: 4] = 4'd9;
         dig = count[4*d +: 4];
         if (carry) begin
            if (upDown) begin
               if (dig >= DIGIT_MAX) begin
                  count_next[4*d +: 4] = 4'd0;
               end else begin
                  count_next[4*d +: 4] = dig + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (dig == 4'd0) begin
                  count_next[4*d +: 4] = DIGIT_MAX;
               end else begin
                  count_next[4*d +: 4] = dig - 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
   end

   assign terminal = upDown ? (count == count_max) : (count == '0);
   assign step     = enable && (presc == PRESC_LAST);

   // A step taken while terminal is exactly a wrap-around step.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
         presc <= '0;
         wrap  <= 1'b0;
      end else if (load) begin
         count <= load_clamped;
         presc <= '0;
         wrap  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (step) begin
            presc <= '0;
            if (!(terminal && SATURATE != 0)) begin
               count <= count_next;
               wrap  <= terminal;
            end
         end else if (enable) begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Display scan runs freely; only reset touches it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         scan_div <= '0;
         scan_idx <= '0;
      end else if (scan_div == SCAN_LAST) begin
         scan_div <= '0;
         scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
         scan_div <= scan_div + 1'b1;
      end
   end

   always_comb begin
      scan_digit = count[3:0];
      an_sel     = '1;
      for (int d = 0; d < DIGITS; d++) begin
         if (SIW'(d) == scan_idx) begin
            scan_digit = count[4*d +: 4];
            an_sel[d]  = 1'b0;
         end
      end
   end

   seg7_decoder u_decoder (
      .digit (scan_digit),
      .seg7  (glyph)
   );

   // seg7 and an are registered together so the digit select and its glyph
   // always change on the same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         seg7 <= SEG_0;
         an   <= ~(DIGITS'(1));
      end else begin
         seg7 <= glyph;
         an   <= an_sel;
      end
   end

endmodule

// File: tb/tb_multidigit_counter_7seg.sv
// tb_multidigit_counter_7seg
//   Directed bench for multidigit_counter_7seg. Four instances share one set
//   of inputs: 2-digit BCD wrapping, 2-digit BCD saturating, 4-digit hex with
//   TICK_DIV=3, and 1-digit hex.
module tb_multidigit_counter_7seg;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        upDown;
   logic        load;
   logic [15:0] load_value;

   logic [7:0]  bcd_count,  sat_count;
   logic        bcd_term,   sat_term,  tick_term, hex_term;
   logic        bcd_wrap,   sat_wrap,  tick_wrap, hex_wrap;
   logic [6:0]  bcd_seg,    sat_seg,   tick_seg,  hex_seg;
   logic [1:0]  bcd_an,     sat_an;
   logic [15:0] tick_count;
   logic [3:0]  tick_an;
   logic [3:0]  hex_count;
   logic [0:0]  hex_an;

   int vectors     = 0;
   int miscompares = 0;

   logic [6:0] glyph_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   always #5 clk = ~clk;

   multidigit_counter_7seg #(.DIGITS(2), .BCD(1), .SATURATE(0), .TICK_DIV(1), .SCAN_DIV(4)) u_bcd2 (
      .clk(clk), .rst(rst), .enable(enable), .upDown(upDown), .load(load),
      .load_value(load_value[7:0]), .count(bcd_count), .terminal(bcd_term),
      .wrap(bcd_wrap), .seg7(bcd_seg), .an(bcd_an)
   );

   multidigit_counter_7seg #(.DIGITS(2), .BCD(1), .SATURATE(1), .TICK_DIV(1), .SCAN_DIV(4)) u_sat (
      .clk(clk), .rst(rst), .enable(enable), .upDown(upDown), .load(load),
      .load_value(load_value[7:0]), .count(sat_count), .terminal(sat_term),
      .wrap(sat_wrap), .seg7(sat_seg), .an(sat_an)
   );

   multidigit_counter_7seg #(.DIGITS(4), .BCD(0), .SATURATE(0), .TICK_DIV(3), .SCAN_DIV(4)) u_tick (
      .clk(clk), .rst(rst), .enable(enable), .upDown(upDown), .load(load),
      .load_value(load_value), .count(tick_count), .terminal(tick_term),
      .wrap(tick_wrap), .seg7(tick_seg), .an(tick_an)
   );

   multidigit_counter_7seg #(.DIGITS(1), .BCD(0), .SATURATE(0), .TICK_DIV(1), .SCAN_DIV(4)) u_hex1 (
      .clk(clk), .rst(rst), .enable(enable), .upDown(upDown), .load(load),
      .load_value(load_value[3:0]), .count(hex_count), .terminal(hex_term),
      .wrap(hex_wrap), .seg7(hex_seg), .an(hex_an)
   );

   // Advance one edge; outputs are sampled and inputs driven 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; load = 1'b0; enable = 1'b0; upDown = 1'b1; load_value = '0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; load = 1'b1; enable = 1'b1; upDown = 1'b1; load_value = 16'hFFFF;
      tick();
      load = 1'b0; enable = 1'b0;
      vectors++; if (bcd_count !== 8'h00) begin miscompares++; $display("FAIL reset_count: got %h expected 00", bcd_count); end
      vectors++; if (bcd_wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap: got %b expected 0", bcd_wrap); end
      vectors++; if (bcd_an !== 2'b10) begin miscompares++; $display("FAIL reset_an: got %b expected 10", bcd_an); end
      vectors++; if (bcd_seg !== 7'b0000001) begin miscompares++; $display("FAIL reset_seg7: got %b expected 0000001", bcd_seg); end
      vectors++; if (bcd_term !== 1'b0) begin miscompares++; $display("FAIL reset_terminal: got %b expected 0", bcd_term); end
      vectors++; if (tick_count !== 16'h0000) begin miscompares++; $display("FAIL reset_tick_count: got %h expected 0000", tick_count); end
      vectors++; if (tick_an !== 4'b1110) begin miscompares++; $display("FAIL reset_tick_an: got %b expected 1110", tick_an); end
      rst = 1'b1;
   endtask

   task automatic test_bcd_count();
      logic seen0, seen1;
      do_reset();
      enable = 1'b1; upDown = 1'b1;
      repeat (10) tick();
      enable = 1'b0;
      vectors++; if (bcd_count !== 8'h10) begin miscompares++; $display("FAIL bcd_count10: got %h expected 10", bcd_count); end
      seen0 = 1'b0; seen1 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (bcd_an == 2'b10 && bcd_seg == 7'b0000001) seen0 = 1'b1;
         if (bcd_an == 2'b01 && bcd_seg == 7'b1001111) seen1 = 1'b1;
      end
      vectors++; if (seen0 !== 1'b1) begin miscompares++; $display("FAIL scan_digit0: got seen=%b expected 1 (an=10 seg7=0000001)", seen0); end
      vectors++; if (seen1 !== 1'b1) begin miscompares++; $display("FAIL scan_digit1: got seen=%b expected 1 (an=01 seg7=1001111)", seen1); end
   endtask

   task automatic test_bcd_wrap();
      enable = 1'b0; upDown = 1'b1; load = 1'b1; load_value = 16'h0099;
      tick();
      load = 1'b0;
      vectors++; if (bcd_count !== 8'h99) begin miscompares++; $display("FAIL wrap_load99: got %h expected 99", bcd_count); end
      vectors++; if (bcd_wrap !== 1'b0) begin miscompares++; $display("FAIL wrap_load_nowrap: got %b expected 0", bcd_wrap); end
      vectors++; if (bcd_term !== 1'b1) begin miscompares++; $display("FAIL wrap_term_up: got %b expected 1", bcd_term); end
      enable = 1'b1; tick(); enable = 1'b0;
      vectors++; if (bcd_count !== 8'h00) begin miscompares++; $display("FAIL wrap_up_count: got %h expected 00", bcd_count); end
      vectors++; if (bcd_wrap !== 1'b1) begin miscompares++; $display("FAIL wrap_up_pulse: got %b expected 1", bcd_wrap); end
      tick();
      vectors++; if (bcd_wrap !== 1'b0) begin miscompares++; $display("FAIL wrap_up_pulse_end: got %b expected 0", bcd_wrap); end
      upDown = 1'b0; #1;
      vectors++; if (bcd_term !== 1'b1) begin miscompares++; $display("FAIL wrap_term_down: got %b expected 1", bcd_term); end
      enable = 1'b1; tick(); enable = 1'b0;
      vectors++; if (bcd_count !== 8'h99) begin miscompares++; $display("FAIL wrap_down_count: got %h expected 99", bcd_count); end
      vectors++; if (bcd_wrap !== 1'b1) begin miscompares++; $display("FAIL wrap_down_pulse: got %b expected 1", bcd_wrap); end
      tick();
      vectors++; if (bcd_wrap !== 1'b0) begin miscompares++; $display("FAIL wrap_down_pulse_end: got %b expected 0", bcd_wrap); end
   endtask

   task automatic test_saturate();
      upDown = 1'b1; enable = 1'b0; load = 1'b1; load_value = 16'h0098;
      tick();
      load = 1'b0; enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++; if (sat_wrap !== 1'b0) begin miscompares++; $display("FAIL sat_nowrap step%0d: got %b expected 0", i, sat_wrap); end
      end
      enable = 1'b0;
      vectors++; if (sat_count !== 8'h99) begin miscompares++; $display("FAIL sat_hold: got %h expected 99", sat_count); end
      vectors++; if (sat_term !== 1'b1) begin miscompares++; $display("FAIL sat_terminal: got %b expected 1", sat_term); end
      tick();
      vectors++; if (sat_wrap !== 1'b0) begin miscompares++; $display("FAIL sat_nowrap_after: got %b expected 0", sat_wrap); end
      load = 1'b1; load_value = 16'h00AF;
      tick();
      load = 1'b0;
      vectors++; if (sat_count !== 8'h99) begin miscompares++; $display("FAIL sat_load_clamp: got %h expected 99", sat_count); end
      vectors++; if (tick_count !== 16'h00AF) begin miscompares++; $display("FAIL hex_load_raw: got %h expected 00af", tick_count); end
   endtask

   task automatic test_tick_div();
      logic [15:0] exp_after [9] = '{16'h0, 16'h0, 16'h1, 16'h1, 16'h1, 16'h2, 16'h2, 16'h2, 16'h3};
      do_reset();
      upDown = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i == 4) begin
            enable = 1'b0;
            repeat (5) tick();
            vectors++; if (tick_count !== 16'h1) begin miscompares++; $display("FAIL tick_freeze: got %h expected 0001", tick_count); end
         end
         enable = 1'b1;
         tick();
         vectors++; if (tick_count !== exp_after[i]) begin miscompares++; $display("FAIL tick_en%0d: got %h expected %h", i + 1, tick_count, exp_after[i]); end
      end
      enable = 1'b0;
   endtask

   task automatic test_hex_glyphs();
      do_reset();
      upDown = 1'b1;
      vectors++; if (hex_seg !== glyph_tab[0]) begin miscompares++; $display("FAIL glyph_0: got %b expected %b", hex_seg, glyph_tab[0]); end
      vectors++; if (hex_an !== 1'b0) begin miscompares++; $display("FAIL hex_an: got %b expected 0", hex_an); end
      for (int i = 1; i < 16; i++) begin
         enable = 1'b1; tick(); enable = 1'b0;
         tick();
         vectors++; if (hex_count !== 4'(i)) begin miscompares++; $display("FAIL hex_count_%0d: got %h expected %h", i, hex_count, 4'(i)); end
         vectors++; if (hex_seg !== glyph_tab[i]) begin miscompares++; $display("FAIL glyph_%0d: got %b expected %b", i, hex_seg, glyph_tab[i]); end
      end
      vectors++; if (hex_term !== 1'b1) begin miscompares++; $display("FAIL hex_terminal: got %b expected 1", hex_term); end
      enable = 1'b1; tick(); enable = 1'b0;
      vectors++; if (hex_count !== 4'h0) begin miscompares++; $display("FAIL hex_wrap_count: got %h expected 0", hex_count); end
      vectors++; if (hex_wrap !== 1'b1) begin miscompares++; $display("FAIL hex_wrap_pulse: got %b expected 1", hex_wrap); end
      tick();
      vectors++; if (hex_wrap !== 1'b0) begin miscompares++; $display("FAIL hex_wrap_end: got %b expected 0", hex_wrap); end
      vectors++; if (hex_seg !== glyph_tab[0]) begin miscompares++; $display("FAIL hex_wrap_glyph: got %b expected %b", hex_seg, glyph_tab[0]); end
   endtask

   task automatic test_reset_override();
      upDown = 1'b1; enable = 1'b0; load = 1'b1; load_value = 16'h0037;
      tick();
      load = 1'b0;
      vectors++; if (bcd_count !== 8'h37) begin miscompares++; $display("FAIL ovr_load37: got %h expected 37", bcd_count); end
      rst = 1'b0; load = 1'b1; load_value = 16'h0055; enable = 1'b1;
      tick();
      rst = 1'b1; load = 1'b0;
      vectors++; if (bcd_count !== 8'h00) begin miscompares++; $display("FAIL ovr_count: got %h expected 00", bcd_count); end
      vectors++; if (bcd_an !== 2'b10) begin miscompares++; $display("FAIL ovr_an: got %b expected 10", bcd_an); end
      vectors++; if (bcd_seg !== 7'b0000001) begin miscompares++; $display("FAIL ovr_seg7: got %b expected 0000001", bcd_seg); end
      vectors++; if (bcd_wrap !== 1'b0) begin miscompares++; $display("FAIL ovr_wrap: got %b expected 0", bcd_wrap); end
      tick();
      enable = 1'b0;
      vectors++; if (bcd_count !== 8'h01) begin miscompares++; $display("FAIL ovr_resume: got %h expected 01", bcd_count); end
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; upDown = 1'b1; load = 1'b0; load_value = '0;
      tick();
      test_reset();
      test_bcd_count();
      test_bcd_wrap();
      test_saturate();
      test_tick_div();
      test_hex_glyphs();
      test_reset_override();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
